// File: rtl/rec_buf_cef_rot_ctrl.sv
// -----------------------------------------------------------------------------
// rec_buf_cef_rot_ctrl
//
// Purpose:
//   Sequences a three-buffer rotating coefficient store sitting between the
//   reconstruction (rec) stage and the entropy-coding (ec) stage. Each CTU
//   step moves through three slots: rec-write, hold, ec-read. For every step
//   the controller issues start pulses to the active stages, waits for their
//   done pulses and then emits one rotate pulse to the buffer. A frame of N
//   CTUs takes N+2 rotations; CTU k is written at step k and read at step k+2.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   start_i      frame start pulse, accepted only while idle
//   ctu_num_i    number of CTUs in the frame, sampled with start_i
//   rec_start_o  one-cycle pulse: rec may begin writing CTU rec_idx_o
//   rec_idx_o    CTU index of the current rec job
//   rec_done_i   pulse: rec finished the current CTU
//   ec_start_o   one-cycle pulse: ec may begin reading CTU ec_idx_o
//   ec_idx_o     CTU index of the current ec job
//   ec_done_i    pulse: ec finished the current CTU
//   rotate_o     one-cycle pulse to the buffer rotate input
//   busy_o       high from start acceptance until done_o
//   done_o       one-cycle pulse: frame drained
// -----------------------------------------------------------------------------
module rec_buf_cef_rot_ctrl #(
  parameter int CTU_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CTU_W-1:0] ctu_num_i,
  output logic             rec_start_o,
  output logic [CTU_W-1:0] rec_idx_o,
  input  logic             rec_done_i,
  output logic             ec_start_o,
  output logic [CTU_W-1:0] ec_idx_o,
  input  logic             ec_done_i,
  output logic             rotate_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ROT   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [CTU_W-1:0] r_ctu_num;
  logic [CTU_W-1:0] r_rec_cnt;
  logic [CTU_W-1:0] r_ec_cnt;
  logic             r_v_rec;
  logic             r_v_mid;
  logic             r_v_ec;
  logic             r_rec_pend;
  logic             r_ec_pend;

  logic             w_start_ok;
  logic             w_rec_more;
  logic             w_rec_pend_next;
  logic             w_ec_pend_next;

  // A zero-length frame is not a frame: it is dropped without leaving idle.
  assign w_start_ok = start_i && (ctu_num_i != '0);

  // One extra bit so rec_cnt+1 cannot wrap when N is the largest count.
  assign w_rec_more = ({1'b0, r_rec_cnt} + {{CTU_W{1'b0}}, 1'b1}) < {1'b0, r_ctu_num};

  // Done pulses only clear a flag that is actually pending.
  assign w_rec_pend_next = r_rec_pend & ~rec_done_i;
  assign w_ec_pend_next  = r_ec_pend  & ~ec_done_i;

  // Indices come straight from the counters; they only change in ROT, so
  // they are stable from ISSUE through WAIT.
  assign rec_idx_o = r_rec_cnt;
  assign ec_idx_o  = r_ec_cnt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    rec_start_o  = 1'b0;
    ec_start_o   = 1'b0;
    rotate_o     = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_next = S_ISSUE;
        end
      end

      S_ISSUE: begin
        busy_o      = 1'b1;
        rec_start_o = r_v_rec;
        ec_start_o  = r_v_ec;
        // A hold-only step has nobody to wait for, so rotate straight away.
        if (r_v_rec || r_v_ec) begin
          w_state_next = S_WAIT;
        end else begin
          w_state_next = S_ROT;
        end
      end

      S_WAIT: begin
        busy_o = 1'b1;
        if (!w_rec_pend_next && !w_ec_pend_next) begin
          w_state_next = S_ROT;
        end
      end

      S_ROT: begin
        busy_o   = 1'b1;
        rotate_o = 1'b1;
        // New valid bits after the shift are {w_rec_more, r_v_rec, r_v_mid}.
        if (w_rec_more || r_v_rec || r_v_mid) begin
          w_state_next = S_ISSUE;
        end else begin
          w_state_next = S_FIN;
        end
      end

      S_FIN: begin
        done_o       = 1'b1;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slot valid bits, pending flags, counters and latched CTU count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctu_num  <= '0;
      r_rec_cnt  <= '0;
      r_ec_cnt   <= '0;
      r_v_rec    <= 1'b0;
      r_v_mid    <= 1'b0;
      r_v_ec     <= 1'b0;
      r_rec_pend <= 1'b0;
      r_ec_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_ctu_num  <= ctu_num_i;
            r_rec_cnt  <= '0;
            r_ec_cnt   <= '0;
            r_v_rec    <= 1'b1;
            r_v_mid    <= 1'b0;
            r_v_ec     <= 1'b0;
            r_rec_pend <= 1'b0;
            r_ec_pend  <= 1'b0;
          end
        end

        S_ISSUE: begin
          // Dones arriving in this cycle are deliberately not applied: the
          // job has only just been started.
          r_rec_pend <= r_v_rec;
          r_ec_pend  <= r_v_ec;
        end

        S_WAIT: begin
          r_rec_pend <= w_rec_pend_next;
          r_ec_pend  <= w_ec_pend_next;
        end

        S_ROT: begin
          r_v_ec  <= r_v_mid;
          r_v_mid <= r_v_rec;
          r_v_rec <= w_rec_more;
          if (r_v_rec) begin
            r_rec_cnt <= r_rec_cnt + 1'b1;
          end
          if (r_v_ec) begin
            r_ec_cnt <= r_ec_cnt + 1'b1;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rec_buf_cef_rot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rec_buf_cef_rot_ctrl
//
// Purpose:
//   Self-checking bench for rec_buf_cef_rot_ctrl. When a frame is started the
//   expected pulse sequence (rec starts, ec starts, rotates, done) is derived
//   from the step rules and pushed into a queue; a monitor pops and compares
//   whenever the DUT pulses an output. A responder answers start pulses with
//   done pulses after fixed or random latencies and records the cycle in
//   which each rotate must appear.
// -----------------------------------------------------------------------------
module tb_rec_buf_cef_rot_ctrl;

  localparam int W = 16;

  localparam int K_REC  = 0;
  localparam int K_EC   = 1;
  localparam int K_ROT  = 2;
  localparam int K_DONE = 3;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic [W-1:0] ctu_num_i;
  logic         rec_start_o;
  logic [W-1:0] rec_idx_o;
  logic         rec_done_i;
  logic         ec_start_o;
  logic [W-1:0] ec_idx_o;
  logic         ec_done_i;
  logic         rotate_o;
  logic         busy_o;
  logic         done_o;

  rec_buf_cef_rot_ctrl #(.CTU_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .ctu_num_i  (ctu_num_i),
    .rec_start_o(rec_start_o),
    .rec_idx_o  (rec_idx_o),
    .rec_done_i (rec_done_i),
    .ec_start_o (ec_start_o),
    .ec_idx_o   (ec_idx_o),
    .ec_done_i  (ec_done_i),
    .rotate_o   (rotate_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  typedef struct {
    int kind;
    int idx;
  } ev_t;

  ev_t exp_q[$];
  int  rot_q[$];

  int  tests;
  int  fails;
  int  cyc;

  // Responder state
  int  rec_tmr;
  int  ec_tmr;
  bit  rec_out;
  bit  ec_out;
  bit  ec_dup;
  int  lat_r;
  int  lat_e;
  bit  rand_lat;
  bit  spur_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, int act, int expv);
    tests = tests + 1;
    if (act != expv) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic string kname(int k);
    case (k)
      K_REC:   return "rec_start";
      K_EC:    return "ec_start";
      K_ROT:   return "rotate";
      default: return "done";
    endcase
  endfunction

  function automatic void pop_chk(int kind, int idx);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL unexpected %s: got pulse idx %0d, required no pulse (cycle %0d)",
               kname(kind), idx, cyc);
    end else begin
      e = exp_q.pop_front();
      chk({kname(kind), " order"}, kind, e.kind);
      chk({kname(kind), " idx"}, idx, e.idx);
      $display("[TB] cycle %0d %s idx %0d", cyc, kname(kind), idx);
    end
  endfunction

  // Reference model: step s writes CTU s (if s<N) and reads CTU s-2 (if
  // 2<=s<N+2); every step ends with one rotate; the frame ends with done.
  function automatic void push_frame(int n);
    ev_t e;
    for (int s = 0; s < n + 2; s++) begin
      if (s < n) begin
        e.kind = K_REC; e.idx = s; exp_q.push_back(e);
      end
      if (s >= 2) begin
        e.kind = K_EC; e.idx = s - 2; exp_q.push_back(e);
      end
      e.kind = K_ROT; e.idx = 0; exp_q.push_back(e);
    end
    e.kind = K_DONE; e.idx = 0; exp_q.push_back(e);
  endfunction

  // Monitor
  initial begin
    int last_rot;
    last_rot = -10;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rec_start_o) begin
          pop_chk(K_REC, int'(rec_idx_o));
          chk("rec_start busy", int'(busy_o), 1);
        end
        if (ec_start_o) begin
          pop_chk(K_EC, int'(ec_idx_o));
          chk("ec_start busy", int'(busy_o), 1);
        end
        if (rotate_o) begin
          pop_chk(K_ROT, 0);
          chk("rotate busy", int'(busy_o), 1);
          if (rot_q.size() > 0) begin
            chk("rotate timing", cyc, rot_q.pop_front());
          end else begin
            chk("hold-step rotate with jobs outstanding", int'(rec_out | ec_out), 0);
          end
          last_rot = cyc;
        end
        if (done_o) begin
          pop_chk(K_DONE, 0);
          chk("done timing", cyc, last_rot + 1);
          chk("done busy", int'(busy_o), 0);
        end
      end
    end
  end

  // One cycle of stimulus: drive defaults, then answer starts with dones.
  task automatic tick();
    bit fired;
    @(negedge clk);
    #1;
    start_i    = 1'b0;
    rec_done_i = 1'b0;
    ec_done_i  = 1'b0;
    fired      = 1'b0;
    if (ec_dup) begin
      ec_done_i = 1'b1;
      ec_dup    = 1'b0;
    end
    if (rec_tmr > 0) begin
      rec_tmr = rec_tmr - 1;
      if (rec_tmr == 0) begin
        rec_done_i = 1'b1;
        rec_out    = 1'b0;
        fired      = 1'b1;
      end
    end
    if (ec_tmr > 0) begin
      ec_tmr = ec_tmr - 1;
      if (ec_tmr == 0) begin
        ec_done_i = 1'b1;
        ec_out    = 1'b0;
        fired     = 1'b1;
        if (spur_en) ec_dup = 1'b1;
      end
    end
    if (fired && !rec_out && !ec_out) rot_q.push_back(cyc + 1);
    if (rec_start_o) begin
      rec_out = 1'b1;
      rec_tmr = rand_lat ? int'($urandom_range(1, 8)) : lat_r;
      if (spur_en) rec_done_i = 1'b1;  // lands in ISSUE, must be ignored
    end
    if (ec_start_o) begin
      ec_out = 1'b1;
      ec_tmr = rand_lat ? int'($urandom_range(1, 8)) : lat_e;
    end
  endtask

  task automatic run_frame(int n, bit mid_start);
    start_i   = 1'b1;
    ctu_num_i = W'(n);
    push_frame(n);
    for (int k = 0; k < 400 && exp_q.size() > 0; k++) begin
      tick();
      if (mid_start && k == 6) begin
        start_i   = 1'b1;
        ctu_num_i = W'(7);
      end
    end
    chk("frame events left", exp_q.size(), 0);
    tick();
    chk("idle busy after frame", int'(busy_o), 0);
    chk("idle done after frame", int'(done_o), 0);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, " rec_start"}, int'(rec_start_o), 0);
    chk({tag, " ec_start"}, int'(ec_start_o), 0);
    chk({tag, " rotate"}, int'(rotate_o), 0);
    chk({tag, " busy"}, int'(busy_o), 0);
    chk({tag, " done"}, int'(done_o), 0);
    chk({tag, " rec_idx"}, int'(rec_idx_o), 0);
    chk({tag, " ec_idx"}, int'(ec_idx_o), 0);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    start_i    = 1'b0;
    rec_done_i = 1'b0;
    ec_done_i  = 1'b0;
    exp_q.delete();
    rot_q.delete();
    rec_tmr = 0; ec_tmr = 0;
    rec_out = 1'b0; ec_out = 1'b0; ec_dup = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("mid-frame reset");
    rst = 1'b0;
  endtask

  initial begin
    bit seen;
    tests = 0; fails = 0;
    rst = 1'b1; start_i = 1'b0; ctu_num_i = '0;
    rec_done_i = 1'b0; ec_done_i = 1'b0;
    rec_tmr = 0; ec_tmr = 0; rec_out = 1'b0; ec_out = 1'b0; ec_dup = 1'b0;
    lat_r = 3; lat_e = 3; rand_lat = 1'b0; spur_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // N=1, both latencies 3
    lat_r = 3; lat_e = 3;
    run_frame(1, 1'b0);

    // N=4, rec 5, ec 9
    lat_r = 5; lat_e = 9;
    run_frame(4, 1'b0);

    // N=3, equal latencies: rec and ec dones coincide at step 2
    lat_r = 4; lat_e = 4;
    run_frame(3, 1'b0);

    // Spurious dones in IDLE, then in ISSUE and duplicate ec done in WAIT
    rec_done_i = 1'b1; ec_done_i = 1'b1;
    tick();
    tick();
    chk("spurious idle busy", int'(busy_o), 0);
    spur_en = 1'b1; lat_r = 6; lat_e = 2;
    run_frame(3, 1'b0);
    spur_en = 1'b0;

    // start with zero CTUs is dropped; start while busy is dropped
    start_i = 1'b1; ctu_num_i = '0;
    tick();
    tick();
    chk("zero-CTU start busy", int'(busy_o), 0);
    lat_r = 3; lat_e = 3;
    run_frame(4, 1'b1);

    // Reset during WAIT of step 2, then a clean N=2 frame
    lat_r = 5; lat_e = 5;
    start_i = 1'b1; ctu_num_i = W'(3);
    push_frame(3);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      if (ec_start_o) seen = 1'b1;
    end
    chk("reached step 2", int'(seen), 1);
    tick();
    tick();
    chk("in wait before reset", int'(busy_o), 1);
    do_reset();
    tick();
    chk("idle after reset busy", int'(busy_o), 0);
    run_frame(2, 1'b0);

    // Randomized frames with random per-job latencies
    rand_lat = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_frame(int'($urandom_range(1, 6)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
